sprite_overlay: RTL

- Pixel-pipeline stage directly downstream of the video timing generator.
- Consumes the generator's signed beam coordinates and its sync/enable strobes.
- Composites up to NUM_SPRITES 16x16 1-bpp sprites over a background colour. Emits RGB plus timing strobes delayed to match.
- Sprite attributes are written by the host/core over a simple register port. Position, colour and enable are double-buffered and applied at frame start.

---
 rtl/sprite_overlay.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sprite_overlay.sv
// sprite_overlay: composites up to NUM_SPRITES 16x16 1-bpp sprites over the background colour
// in a fixed two-stage pipeline; position/colour/enable are double-buffered and swapped at frame start.
module sprite_overlay #(
   parameter int COORD_WIDTH = 16,
   parameter int NUM_SPRITES = 4
) (
   input  logic                          pixel_clock,
   input  logic                          reset_n,
   input  logic signed [COORD_WIDTH-1:0] x,
   input  logic signed [COORD_WIDTH-1:0] y,
   input  logic                          video_enable_in,
   input  logic                          vsync_start_in,
   input  logic                          hsync_start_in,
   input  logic [23:0]                   bg_rgb,
   input  logic                          cfg_we,
   input  logic [7:0]                    cfg_addr,
   input  logic [31:0]                   cfg_wdata,
   output logic [23:0]                   rgb_out,
   output logic                          video_enable_out,
   output logic                          vsync_out,
   output logic                          hsync_out,
   output logic                          collision
);
   localparam int CW = COORD_WIDTH;
   localparam int NS = NUM_SPRITES;

   logic signed [CW-1:0] sx_q [NS];
   logic signed [CW-1:0] sx_d [NS];
   logic signed [CW-1:0] sy_q [NS];
   logic signed [CW-1:0] sy_d [NS];
   logic signed [CW-1:0] ax_q [NS];
   logic signed [CW-1:0] ay_q [NS];
   logic [23:0]          scol_q [NS];
   logic [23:0]          scol_d [NS];
   logic [23:0]          acol_q [NS];
   logic [23:0]          col_q [NS];
   logic [NS-1:0]        sen_q, sen_d, aen_q, hit, hit_q;
   logic [15:0]          bm_q [NS][16];
   logic [15:0]          bm_d [NS][16];
   logic [CW:0]          dx [NS];
   logic [CW:0]          dy [NS];
   logic [4:0]           row;
   logic                 multi, acc_q, acc_d;
   logic                 ven1_q, vs1_q, hs1_q;
   logic [23:0]          bg1_q, pick;

   // selects 3..18 map to rows 0..15; everything else lands outside 0..15
   assign row = cfg_addr[4:0] - 5'd3;

   always_comb begin
      sx_d = sx_q;
      sy_d = sy_q;
      scol_d = scol_q;
      sen_d = sen_q;
      bm_d = bm_q;
      for (int i = 0; i < NS; i++) begin
         if (cfg_we && cfg_addr[7:5] == 3'(i)) begin
            if (cfg_addr[4:0] == 5'd0) sx_d[i] = cfg_wdata[CW-1:0];
            if (cfg_addr[4:0] == 5'd1) sy_d[i] = cfg_wdata[CW-1:0];
            if (cfg_addr[4:0] == 5'd2) begin
               scol_d[i] = cfg_wdata[23:0];
               sen_d[i] = cfg_wdata[31];
            end
            if (row < 5'd16) bm_d[i][row[3:0]] = cfg_wdata[15:0];
         end
      end
   end

   // one extra bit keeps the offset exact across the whole coordinate range
   always_comb begin
      for (int i = 0; i < NS; i++) begin
         dx[i] = {x[CW-1], x} - {ax_q[i][CW-1], ax_q[i]};
         dy[i] = {y[CW-1], y} - {ay_q[i][CW-1], ay_q[i]};
         hit[i] = aen_q[i] && dx[i][CW:4] == '0 && dy[i][CW:4] == '0 && bm_q[i][dy[i][3:0]][~dx[i][3:0]];
      end
   end

   assign multi = video_enable_in && |(hit & (hit - 1'b1));
   assign acc_d = vsync_start_in ? multi : acc_q | multi;

   always_comb begin
      pick = bg1_q;
      for (int i = NS - 1; i >= 0; i--) pick = hit_q[i] ? col_q[i] : pick;
   end

   always_ff @(posedge pixel_clock) begin
      if (!reset_n) begin
         for (int i = 0; i < NS; i++) begin
            sx_q[i] <= '0;
            sy_q[i] <= '0;
            ax_q[i] <= '0;
            ay_q[i] <= '0;
            scol_q[i] <= '0;
            acol_q[i] <= '0;
            col_q[i] <= '0;
            for (int r = 0; r < 16; r++) bm_q[i][r] <= '0;
         end
         sen_q <= '0;
         aen_q <= '0;
         hit_q <= '0;
         acc_q <= 1'b0;
         collision <= 1'b0;
         ven1_q <= 1'b0;
         vs1_q <= 1'b0;
         hs1_q <= 1'b0;
         bg1_q <= '0;
         rgb_out <= '0;
         video_enable_out <= 1'b0;
         vsync_out <= 1'b0;
         hsync_out <= 1'b0;
      end else begin
         sx_q <= sx_d;
         sy_q <= sy_d;
         scol_q <= scol_d;
         sen_q <= sen_d;
         bm_q <= bm_d;
         if (vsync_start_in) begin
            ax_q <= sx_q;
            ay_q <= sy_q;
            acol_q <= scol_q;
            aen_q <= sen_q;
            collision <= acc_q;
         end
         acc_q <= acc_d;
         hit_q <= hit;
         col_q <= acol_q;
         ven1_q <= video_enable_in;
         vs1_q <= vsync_start_in;
         hs1_q <= hsync_start_in;
         bg1_q <= bg_rgb;
         rgb_out <= ven1_q ? pick : '0;
         video_enable_out <= ven1_q;
         vsync_out <= vs1_q;
         hsync_out <= hs1_q;
      end
   end
endmodule
